// File: rtl/window3x3_linebuf_if.sv
// Bundle of the pixel-in and window-out handshakes of window3x3_linebuf.
// master = pixel source / window sink, slave = the window generator.
// out_min exists only when WIN_MIN_EN is defined.
interface window3x3_linebuf_if #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8
);
  logic                        in_valid;
  logic                        in_ready;
  logic [DATA_WIDTH-1:0]       in_pixel;
  logic                        in_sof;
  logic                        out_valid;
  logic                        out_ready;
  logic [9*DATA_WIDTH-1:0]     out_win;
  logic [$clog2(IMG_H)-1:0]    out_row;
  logic [$clog2(IMG_W)-1:0]    out_col;
  logic                        out_last;
  logic                        sof_err;
`ifdef WIN_MIN_EN
  logic [DATA_WIDTH-1:0]       out_min;
`endif

  modport master (
    output in_valid, in_pixel, in_sof, out_ready,
    input  in_ready, out_valid, out_win, out_row, out_col, out_last, sof_err
`ifdef WIN_MIN_EN
    , input out_min
`endif
  );

  modport slave (
    input  in_valid, in_pixel, in_sof, out_ready,
    output in_ready, out_valid, out_win, out_row, out_col, out_last, sof_err
`ifdef WIN_MIN_EN
    , output out_min
`endif
  );
endinterface

// File: rtl/window3x3_linebuf.sv
// Streaming 3x3 sliding-window generator (two line buffers + column shift register).
// Latency: window registered on the edge that accepts pixel (r>=2,c>=2), i.e. 1 cycle.
// Backpressure: in_ready = !out_valid || out_ready; a pending window holds every output.
// Optional feature macro WIN_MIN_EN adds out_min, the registered minimum of the 9 elements.
module window3x3_linebuf #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  window3x3_linebuf_if.slave    io_bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef logic [DATA_WIDTH-1:0] pix_t;

  // frame position of the next pixel to be accepted
  logic [CW-1:0]          r_col;
  logic [RW-1:0]          r_row;
  // line buffers: r_lb1 holds row r-1, r_lb2 holds row r-2 (not reset)
  pix_t                   r_lb1 [IMG_W];
  pix_t                   r_lb2 [IMG_W];
  // two previous columns of the window, index 0 = top (row r-2)
  logic [2:0][DATA_WIDTH-1:0] r_cm2;
  logic [2:0][DATA_WIDTH-1:0] r_cm1;
  // output register
  logic                   r_out_valid;
  logic [9*DATA_WIDTH-1:0] r_out_win;
  logic [RW-1:0]          r_out_row;
  logic [CW-1:0]          r_out_col;
  logic                   r_out_last;
  logic                   r_sof_err;

  logic                   w_acc;
  logic [CW-1:0]          w_c;
  logic [RW-1:0]          w_r;
  logic [CW-1:0]          w_c_nxt;
  logic [RW-1:0]          w_r_nxt;
  logic [2:0][DATA_WIDTH-1:0] w_col;
  logic [9*DATA_WIDTH-1:0] w_win;
  logic                   w_emit;
  logic                   w_sof_bad;

  assign io_bus.in_ready  = !r_out_valid || io_bus.out_ready;
  assign w_acc            = io_bus.in_valid && io_bus.in_ready;
  assign w_sof_bad        = io_bus.in_sof && ((r_col != '0) || (r_row != '0));

  // position of the pixel being accepted: in_sof forces it to the frame origin
  always_comb begin
    w_c = r_col;
    w_r = r_row;
    if (io_bus.in_sof) begin
      w_c = '0;
      w_r = '0;
    end
  end

  // raster advance from the accepted position, wrapping at end of row and frame
  always_comb begin
    w_c_nxt = w_c + CW'(1);
    w_r_nxt = w_r;
    if (w_c == COL_LAST) begin
      w_c_nxt = '0;
      w_r_nxt = (w_r == ROW_LAST) ? '0 : w_r + RW'(1);
    end
  end

  // assemble the current column and the full 3x3 window for this pixel
  always_comb begin
    w_col    = '0;
    w_win    = '0;
    w_col[0] = r_lb2[w_c];
    w_col[1] = r_lb1[w_c];
    w_col[2] = io_bus.in_pixel;
    for (int m = 0; m < 3; m++) begin
      w_win[(3*m+0)*DATA_WIDTH +: DATA_WIDTH] = r_cm2[m];
      w_win[(3*m+1)*DATA_WIDTH +: DATA_WIDTH] = r_cm1[m];
      w_win[(3*m+2)*DATA_WIDTH +: DATA_WIDTH] = w_col[m];
    end
  end

  // only fully interior positions produce a window; this also hides stale line data
  assign w_emit = w_acc && (w_r >= ROW_TWO) && (w_c >= COL_TWO);

  // position counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_acc) begin
      r_col <= w_c_nxt;
      r_row <= w_r_nxt;
    end
  end

  // line buffers and column shift register, shifted on every accepted pixel
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_lb2[w_c] <= r_lb1[w_c];
      r_lb1[w_c] <= io_bus.in_pixel;
      r_cm2      <= r_cm1;
      r_cm1      <= w_col;
    end
  end

  // output register: load on emit, otherwise drop valid once it is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_win   <= '0;
      r_out_row   <= '0;
      r_out_col   <= '0;
      r_out_last  <= 1'b0;
      r_sof_err   <= 1'b0;
    end else begin
      r_sof_err <= w_acc && w_sof_bad;
      if (w_emit) begin
        r_out_valid <= 1'b1;
        r_out_win   <= w_win;
        r_out_row   <= w_r - ROW_TWO;
        r_out_col   <= w_c - COL_TWO;
        r_out_last  <= (w_r == ROW_LAST) && (w_c == COL_LAST);
      end else if (io_bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_win   = r_out_win;
  assign io_bus.out_row   = r_out_row;
  assign io_bus.out_col   = r_out_col;
  assign io_bus.out_last  = r_out_last;
  assign io_bus.sof_err   = r_sof_err;

`ifdef WIN_MIN_EN
  pix_t               r_out_min;
  logic [2:0][DATA_WIDTH-1:0] w_row_min;
  pix_t               w_min;

  function automatic pix_t min2(input pix_t a, input pix_t b);
    return (a < b) ? a : b;
  endfunction

  // two-level compare tree: per-row minimum, then minimum of the three rows
  always_comb begin
    w_row_min = '0;
    for (int m = 0; m < 3; m++) begin
      w_row_min[m] = min2(min2(w_win[(3*m+0)*DATA_WIDTH +: DATA_WIDTH],
                               w_win[(3*m+1)*DATA_WIDTH +: DATA_WIDTH]),
                          w_win[(3*m+2)*DATA_WIDTH +: DATA_WIDTH]);
    end
    w_min = min2(min2(w_row_min[0], w_row_min[1]), w_row_min[2]);
  end

  // minimum is registered alongside the window so it shares its hold behaviour
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_min <= '0;
    end else if (w_emit) begin
      r_out_min <= w_min;
    end
  end

  assign io_bus.out_min = r_out_min;
`endif

endmodule
